dmem_responder: RTL and testbench

Data-memory responder for the two-cycle `mem_*` bus driven by the load/store ALU. It holds a word-organised SRAM and decodes each request against a base/size window. It returns read data and an error flag in the second request cycle, and commits byte-enabled writes at the end of that cycle. A word-wide loader port allows the memory image to be preloaded or patched outside bus transactions.

---
 rtl/dmem_responder.sv | 134 +++++++++++++
 tb/tb_dmem_responder.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : dmem_responder
// Brief    : Two-cycle mem_* bus data-memory responder. Word-organised SRAM
//            with base/size window decode, byte-enabled stores committed at
//            the end of the access cycle, and a word-wide loader port.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_responder #(
    parameter int                 XLEN        = 32,
    parameter int                 DEPTH_WORDS = 1024,
    parameter logic [XLEN-1:0]    BASE_ADDR   = 32'h0000_0000
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           mem_req,
    input  logic [XLEN-1:0]                mem_addr,
    input  logic                           mem_we,
    input  logic [XLEN-1:0]                mem_wdata,
    input  logic [XLEN/8-1:0]              mem_byteen,
    output logic [XLEN-1:0]                mem_rdata,
    output logic                           mem_err,
    input  logic                           ld_we,
    input  logic [$clog2(DEPTH_WORDS)-1:0] ld_idx,
    input  logic [XLEN-1:0]                ld_wdata
);

    localparam int              IW     = $clog2(DEPTH_WORDS);
    localparam int              NB     = XLEN / 8;
    localparam logic [XLEN-1:0] DEPTH_X = XLEN'(DEPTH_WORDS);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [IW-1:0]     idx_q,   idx_d;
    logic              inr_q,   inr_d;
    logic              we_q,    we_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic [XLEN-1:0]   rd_q,    rd_d;

    // Memory contents are deliberately not reset.
    logic [XLEN-1:0]   mem [DEPTH_WORDS];

    logic [XLEN-1:0]   offset;
    logic [XLEN-1:0]   word_off;
    logic              in_range;
    logic [IW-1:0]     req_idx;
    logic              bus_wr;

    // Window decode in unsigned XLEN arithmetic; below-base addresses never wrap in.
    always_comb begin
        offset   = mem_addr - BASE_ADDR;
        word_off = offset >> 2;
        in_range = (mem_addr >= BASE_ADDR) && (word_off < DEPTH_X);
        req_idx  = word_off[IW-1:0];
    end

    // Next-state, capture and output logic for the request FSM.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        inr_d     = inr_q;
        we_d      = we_q;
        wdata_d   = wdata_q;
        rd_d      = rd_q;
        mem_rdata = '0;
        mem_err   = 1'b0;
        bus_wr    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (mem_req) begin
                    idx_d   = req_idx;
                    inr_d   = in_range;
                    we_d    = mem_we;
                    wdata_d = mem_wdata;
                    rd_d    = in_range ? mem[req_idx] : '0;
                    state_d = S_ACCESS;
                end
            end
            S_ACCESS: begin
                mem_rdata = (!we_q && inr_q) ? rd_q : '0;
                mem_err   = !inr_q || (mem_byteen == '0);
                bus_wr    = we_q && inr_q && (mem_byteen != '0);
                state_d   = S_DONE;
            end
            S_DONE: begin
                // Absorbs an over-long request; req must drop before a new one.
                if (!mem_req) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control and capture registers; reset aborts any transaction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            inr_q   <= 1'b0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            rd_q    <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            inr_q   <= inr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            rd_q    <= rd_d;
        end
    end

    // Array writes: loader first, bus lanes afterwards so the bus wins on a collision.
    always_ff @(posedge clk) begin
        if (ld_we) begin
            mem[ld_idx] <= ld_wdata;
        end
        for (int b = 0; b < NB; b++) begin
            if (bus_wr && mem_byteen[b]) begin
                mem[idx_q][b*8 +: 8] <= wdata_q[b*8 +: 8];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_responder
// Brief    : Directed self-checking bench for dmem_responder. Two instances
//            share the bus/loader inputs: base 0x0 and base 0x100.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_byteen;
    logic        ld_we;
    logic [9:0]  ld_idx;
    logic [31:0] ld_wdata;
    logic [31:0] rdata1, rdata2;
    logic        err1, err2;

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0] rd1;
        logic        e1;
        logic [31:0] rd2;
        logic        e2;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    dmem_responder #(.XLEN(32), .DEPTH_WORDS(1024), .BASE_ADDR(32'h0000_0000)) u_dut (
        .clk(clk), .rst_n(rst_n), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_byteen(mem_byteen),
        .mem_rdata(rdata1), .mem_err(err1),
        .ld_we(ld_we), .ld_idx(ld_idx), .ld_wdata(ld_wdata)
    );

    dmem_responder #(.XLEN(32), .DEPTH_WORDS(1024), .BASE_ADDR(32'h0000_0100)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_byteen(mem_byteen),
        .mem_rdata(rdata2), .mem_err(err2),
        .ld_we(ld_we), .ld_idx(ld_idx), .ld_wdata(ld_wdata)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] rd1, input logic e1, input logic [31:0] rd2, input logic e2);
        exp_t e;
        e.rd1 = rd1; e.e1 = e1; e.rd2 = rd2; e.e2 = e2;
        sb.push_back(e);
    endtask

    task automatic load_word(input logic [9:0] idx, input logic [31:0] data);
        @(negedge clk);
        ld_we = 1'b1; ld_idx = idx; ld_wdata = data;
        @(negedge clk);
        ld_we = 1'b0;
    endtask

    // One bus transaction; optionally a loader write lands on the commit edge.
    task automatic txn(input string tag, input logic [31:0] a, input logic w,
                       input logic [31:0] wd, input logic [3:0] be,
                       input bit coll, input logic [9:0] cidx, input logic [31:0] cdata);
        exp_t e;
        @(negedge clk);
        mem_req = 1'b1; mem_addr = a; mem_we = w; mem_wdata = wd; mem_byteen = 4'b0000;
        @(negedge clk);
        mem_byteen = be;
        if (coll) begin
            ld_we = 1'b1; ld_idx = cidx; ld_wdata = cdata;
        end
        #1;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check({tag, "_rdata"}, rdata1, e.rd1);
            check({tag, "_err"},   {31'd0, err1}, {31'd0, e.e1});
            check({tag, "_rdata_b100"}, rdata2, e.rd2);
            check({tag, "_err_b100"},   {31'd0, err2}, {31'd0, e.e2});
        end
        @(negedge clk);
        mem_req = 1'b0; mem_byteen = 4'b0000; ld_we = 1'b0; mem_we = 1'b0; mem_addr = '0;
        #1;
        check({tag, "_done_rdata"}, rdata1, 32'd0);
        check({tag, "_done_err"}, {31'd0, err1}, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; mem_req = 1'b0; mem_addr = '0; mem_we = 1'b0; mem_wdata = '0;
        mem_byteen = '0; ld_we = 1'b0; ld_idx = '0; ld_wdata = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("reset_rdata", rdata1, 32'd0);
        check("reset_err", {31'd0, err1}, 32'd0);

        // Load word
        load_word(10'd4, 32'hDEAD_BEEF);
        push(32'hDEAD_BEEF, 1'b0, 32'd0, 1'b1);
        txn("load_word", 32'h10, 1'b0, 32'd0, 4'b1111, 1'b0, '0, '0);

        // Byte store then reload
        load_word(10'd2, 32'h1122_3344);
        push(32'd0, 1'b0, 32'd0, 1'b1);
        txn("byte_store", 32'h0A, 1'b1, 32'h00AB_0000, 4'b0100, 1'b0, '0, '0);
        push(32'h11AB_3344, 1'b0, 32'd0, 1'b1);
        txn("byte_store_rd", 32'h08, 1'b0, 32'd0, 4'b1111, 1'b0, '0, '0);

        // Out of range just past the top (in range for the base-0x100 instance)
        load_word(10'd0, 32'hCAFE_F00D);
        push(32'd0, 1'b1, 32'd0, 1'b0);
        txn("oor_top", 32'h1000, 1'b1, 32'hFFFF_FFFF, 4'b1111, 1'b0, '0, '0);
        push(32'hCAFE_F00D, 1'b0, 32'd0, 1'b1);
        txn("oor_top_rd", 32'h0, 1'b0, 32'd0, 4'b1111, 1'b0, '0, '0);

        // Just below base for the base-0x100 instance; first word of its window
        load_word(10'd63, 32'h0BAD_CAFE);
        load_word(10'd64, 32'h6464_6464);
        push(32'h0BAD_CAFE, 1'b0, 32'd0, 1'b1);
        txn("below_base", 32'h0FC, 1'b0, 32'd0, 4'b1111, 1'b0, '0, '0);
        push(32'h6464_6464, 1'b0, 32'hCAFE_F00D, 1'b0);
        txn("base_word0", 32'h100, 1'b0, 32'd0, 4'b1111, 1'b0, '0, '0);

        // Zero byte enables
        load_word(10'd8, 32'h1234_5678);
        push(32'd0, 1'b1, 32'd0, 1'b1);
        txn("zero_be", 32'h20, 1'b1, 32'hFFFF_FFFF, 4'b0000, 1'b0, '0, '0);
        push(32'h1234_5678, 1'b0, 32'd0, 1'b1);
        txn("zero_be_rd", 32'h20, 1'b0, 32'd0, 4'b1111, 1'b0, '0, '0);

        // Bus/loader collision on the same index and edge
        load_word(10'd3, 32'h0000_0000);
        push(32'd0, 1'b0, 32'd0, 1'b1);
        txn("collide", 32'h0C, 1'b1, 32'h0000_00AA, 4'b0001, 1'b1, 10'd3, 32'h5566_7788);
        push(32'h5566_77AA, 1'b0, 32'd0, 1'b1);
        txn("collide_rd", 32'h0C, 1'b0, 32'd0, 4'b1111, 1'b0, '0, '0);

        // Reset during the access cycle of a load: outputs drop immediately
        @(negedge clk);
        mem_req = 1'b1; mem_addr = 32'h10; mem_we = 1'b0; mem_byteen = 4'b0000;
        @(negedge clk);
        mem_byteen = 4'b1111;
        #1;
        check("rst_ld_pre", rdata1, 32'hDEAD_BEEF);
        rst_n = 1'b0;
        #1;
        check("rst_ld_rdata", rdata1, 32'd0);
        check("rst_ld_err", {31'd0, err1}, 32'd0);
        @(negedge clk);
        mem_req = 1'b0; mem_byteen = 4'b0000;
        @(negedge clk);
        rst_n = 1'b1;

        // Reset during the access cycle of a store: no write committed
        load_word(10'd5, 32'hA5A5_A5A5);
        @(negedge clk);
        mem_req = 1'b1; mem_addr = 32'h14; mem_we = 1'b1; mem_wdata = 32'h0; mem_byteen = 4'b0000;
        @(negedge clk);
        mem_byteen = 4'b1111;
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_st_err", {31'd0, err1}, 32'd0);
        @(negedge clk);
        mem_req = 1'b0; mem_byteen = 4'b0000; mem_we = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        push(32'hA5A5_A5A5, 1'b0, 32'd0, 1'b1);
        txn("rst_st_rd", 32'h14, 1'b0, 32'd0, 4'b1111, 1'b0, '0, '0);

        // Request held high for five cycles yields exactly one access cycle
        load_word(10'd6, 32'h0606_0606);
        @(negedge clk);
        mem_req = 1'b1; mem_addr = 32'h18; mem_we = 1'b0; mem_byteen = 4'b0000;
        @(negedge clk);
        mem_byteen = 4'b1111;
        #1;
        check("held_rdata", rdata1, 32'h0606_0606);
        check("held_err", {31'd0, err1}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            check("held_extra_rdata", rdata1, 32'd0);
            check("held_extra_err", {31'd0, err1}, 32'd0);
        end
        @(negedge clk);
        mem_req = 1'b0; mem_byteen = 4'b0000;
        push(32'h0606_0606, 1'b0, 32'd0, 1'b1);
        txn("after_held", 32'h18, 1'b0, 32'd0, 4'b1111, 1'b0, '0, '0);

        check("sb_drained", sb.size(), 32'd0);
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
